id_exe_stage_reg: RTL
=====================

# id_exe_stage_reg

ID/EXE pipeline register for the 5-stage ARM core. It is the consumer end of the hazard interface: it takes the stall decision from hazard detection and turns it into a bubble. It also sources the EXE-stage destination, write-back enable and memory-read enable that hazard detection and forwarding compare against. It adds freeze and branch-flush handling, plus saturating counters for hazard bubbles and flushes.

## Interface
Parameters:
- DATA_W, 32, width of PC and operand values
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- freeze  in  1  global hold (memory stall); register holds every field
- flush  in  1  branch taken in EXE; next content is a bubble
- hazard_detected  in  1  stall request from hazard detection; next content is a bubble
- id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm  in  1 each  ID control bits
- id_exe_cmd  in  4  ALU command
- id_dest, id_src1, id_src2  in  4 each  register numbers
- id_pc, id_val_rn, id_val_rm  in  DATA_W each  PC and operand values
- id_shift_operand  in  12  shifter operand
- id_signed_imm_24  in  24  branch offset
- id_sr  in  4  NZCV flags
- exe_*  out  same widths as id_*  registered copies; exe_wb_en, exe_mem_r_en and exe_dest feed hazard detection and forwarding
- exe_valid  out  1  0 when the EXE slot holds a bubble
- hazard_cnt  out  CNT_W  bubbles inserted due to hazard
- flush_cnt  out  CNT_W  flushes applied

## Operation
- Per-edge priority:
  1. reset (rst_n=0)
  2. freeze
  3. flush
  4. hazard_detected
  5. normal load
- Reset: every output is 0, including exe_valid, both counters, exe_pc and the data fields.
- Freeze: all exe_* fields, exe_valid and both counters hold. freeze overrides a simultaneous flush or hazard.
- Bubble (flush or hazard) sets every field to 0:
  - control: wb_en, mem_r_en, mem_w_en, b, s, imm = 0
  - exe_cmd = CMD_NOP (4'b0000), dest/src1/src2 = 0
  - data fields = 0, exe_valid = 0
- Normal load: every id_* field is copied and exe_valid = 1.
- Counters:
  - hazard_cnt increments by 1 only on an edge where the hazard bubble is actually applied (rst_n=1, freeze=0, flush=0, hazard_detected=1).
  - flush_cnt increments on an edge with rst_n=1, freeze=0, flush=1, whatever hazard_detected is.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Flush and hazard together: one bubble is inserted and only flush_cnt increments.
- Inputs are sampled only at the edge. No combinational path from any input to any output.

## Timing
- Latency: exactly 1 cycle from id_* to exe_*.
- Bubble timing: hazard_detected high in cycle N gives exe_valid=0 in cycle N+1. The stall of PC and IF/ID is handled elsewhere on the same cycle-N signal.
- Sustained hazard over K consecutive unfrozen cycles gives K bubbles and hazard_cnt += K.
- Reset mid-operation takes effect at the next edge and clears all state, counters included. The first load after release is a normal load.
- Freeze released in cycle N: the edge at the end of cycle N applies normal priority to the inputs present then.

## Structure
- The shared package arm_pkg holds:
  - exe_cmd constants (CMD_NOP, CMD_MOV=4'b0001, CMD_MVN=4'b1001, and the rest)
  - a packed struct for the ID/EXE bundle
  - the BUBBLE constant of that struct
- One sub-module, sat_counter (parameter WIDTH; ports clk, rst_n, inc, count), instantiated twice.
- Register bank is a single always block on the struct.

## Test plan
- Reset: rst_n=0 with all id_* = 0xF/0xFFFFFFFF → all outputs 0. After release, id_dest=4'h3, id_wb_en=1 → next cycle exe_dest=3, exe_wb_en=1, exe_valid=1.
- Hazard: id_mem_r_en=1 load, then hazard_detected=1 for 2 cycles → two bubbles (exe_valid=0, exe_wb_en=0, exe_cmd=0); hazard_cnt=2.
- Flush and hazard in the same cycle → one bubble; flush_cnt=1, hazard_cnt unchanged.
- Freeze: freeze=1 with flush=1 and hazard_detected=1 for 3 cycles → exe_* and counters unchanged. After release, id_pc=0x40 loads to exe_pc=0x40.
- Saturation: with CNT_W=4, hold hazard_detected=1 for 20 cycles → hazard_cnt stops at 15.
- Mid-operation reset: rst_n=0 for 1 cycle while hazard_cnt=5 → hazard_cnt=0 and exe_valid=0. Next normal load gives exe_valid=1.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline: ALU commands and the
// ID/EXE register bundle.
package arm_pkg;

    localparam int PKG_DATA_W = 32;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic                  b;
        logic                  s;
        logic                  imm;
        logic [3:0]            exe_cmd;
        logic [3:0]            dest;
        logic [3:0]            src1;
        logic [3:0]            src2;
        logic [PKG_DATA_W-1:0] pc;
        logic [PKG_DATA_W-1:0] val_rn;
        logic [PKG_DATA_W-1:0] val_rm;
        logic [11:0]           shift_operand;
        logic [23:0]           signed_imm_24;
        logic [3:0]            sr;
        logic                  valid;
    } id_ex_t;

    // CMD_NOP is 0, so an all-zero bundle is a well-formed bubble
    localparam id_ex_t BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign count = r_cnt;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register: freeze hold, flush/hazard bubbles and
// saturating counters of bubbles inserted.
module id_exe_stage_reg
    import arm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              hazard_detected,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic              id_b,
    input  logic              id_s,
    input  logic              id_imm,
    input  logic [3:0]        id_exe_cmd,
    input  logic [3:0]        id_dest,
    input  logic [3:0]        id_src1,
    input  logic [3:0]        id_src2,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_val_rn,
    input  logic [DATA_W-1:0] id_val_rm,
    input  logic [11:0]       id_shift_operand,
    input  logic [23:0]       id_signed_imm_24,
    input  logic [3:0]        id_sr,
    output logic              exe_wb_en,
    output logic              exe_mem_r_en,
    output logic              exe_mem_w_en,
    output logic              exe_b,
    output logic              exe_s,
    output logic              exe_imm,
    output logic [3:0]        exe_exe_cmd,
    output logic [3:0]        exe_dest,
    output logic [3:0]        exe_src1,
    output logic [3:0]        exe_src2,
    output logic [DATA_W-1:0] exe_pc,
    output logic [DATA_W-1:0] exe_val_rn,
    output logic [DATA_W-1:0] exe_val_rm,
    output logic [11:0]       exe_shift_operand,
    output logic [23:0]       exe_signed_imm_24,
    output logic [3:0]        exe_sr,
    output logic              exe_valid,
    output logic [CNT_W-1:0]  hazard_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    id_ex_t r_q;
    id_ex_t w_d;
    logic   w_haz_inc;
    logic   w_flush_inc;

    always_comb begin
        w_d               = BUBBLE;
        w_d.wb_en         = id_wb_en;
        w_d.mem_r_en      = id_mem_r_en;
        w_d.mem_w_en      = id_mem_w_en;
        w_d.b             = id_b;
        w_d.s             = id_s;
        w_d.imm           = id_imm;
        w_d.exe_cmd       = id_exe_cmd;
        w_d.dest          = id_dest;
        w_d.src1          = id_src1;
        w_d.src2          = id_src2;
        w_d.pc            = PKG_DATA_W'(id_pc);
        w_d.val_rn        = PKG_DATA_W'(id_val_rn);
        w_d.val_rm        = PKG_DATA_W'(id_val_rm);
        w_d.shift_operand = id_shift_operand;
        w_d.signed_imm_24 = id_signed_imm_24;
        w_d.sr            = id_sr;
        w_d.valid         = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= BUBBLE;
        end else if (!freeze) begin
            if (flush || hazard_detected) begin
                r_q <= BUBBLE;
            end else begin
                r_q <= w_d;
            end
        end
    end

    // A flush shadows a coincident hazard, so only one counter moves
    assign w_flush_inc = !freeze && flush;
    assign w_haz_inc   = !freeze && !flush && hazard_detected;

    sat_counter #(.WIDTH(CNT_W)) u_haz_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_haz_inc),
        .count (hazard_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

    assign exe_wb_en         = r_q.wb_en;
    assign exe_mem_r_en      = r_q.mem_r_en;
    assign exe_mem_w_en      = r_q.mem_w_en;
    assign exe_b             = r_q.b;
    assign exe_s             = r_q.s;
    assign exe_imm           = r_q.imm;
    assign exe_exe_cmd       = r_q.exe_cmd;
    assign exe_dest          = r_q.dest;
    assign exe_src1          = r_q.src1;
    assign exe_src2          = r_q.src2;
    assign exe_pc            = DATA_W'(r_q.pc);
    assign exe_val_rn        = DATA_W'(r_q.val_rn);
    assign exe_val_rm        = DATA_W'(r_q.val_rm);
    assign exe_shift_operand = r_q.shift_operand;
    assign exe_signed_imm_24 = r_q.signed_imm_24;
    assign exe_sr            = r_q.sr;
    assign exe_valid         = r_q.valid;

endmodule
